// File: rtl/demux_pkg.sv
// demux_pkg: shared types for the 1-to-N stream demultiplexer.
// Imported by demultiplexer_1_to_n_stream.
package demux_pkg;

    typedef enum logic {
        MODE_SELECT = 1'b0,
        MODE_RR     = 1'b1
    } demux_mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } demux_state_e;

endpackage

// File: rtl/demux_rr_pointer.sv
// demux_rr_pointer: modulo-N wrap counter used as the round-robin
// destination pointer of the stream demultiplexer.
module demux_rr_pointer #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (ptr == W'(N - 1)) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/demultiplexer_1_to_n_stream.sv
// demultiplexer_1_to_n_stream: registered 1-to-N valid/ready demux.
// Round-robin destination mode is compiled in by DEMUX_ROUND_ROBIN_EN.
module demultiplexer_1_to_n_stream
    import demux_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_OUT  = 4,
    localparam int SEL_W  = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        select_lines,
    input  logic                    mode,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [SEL_W-1:0]        cur_channel,
    output logic                    sel_err
);

    demux_state_e      state;
    logic [DATA_W-1:0] hold_data;
    logic [SEL_W-1:0]  hold_ch;
    logic              full;
    logic              acc;
    logic              drn;
    logic              bad;
    logic              load;
    logic [SEL_W-1:0]  dest;

    demux_state_e             nxt_state;
    logic [DATA_W-1:0]        nxt_data;
    logic [SEL_W-1:0]         nxt_ch;
    logic [N_OUT-1:0]         nxt_valid;
    logic [N_OUT*DATA_W-1:0]  nxt_lanes;

    assign full     = (state == ST_FULL);
    assign in_ready = !reset && (!full || out_ready[hold_ch]);
    assign acc      = in_valid && in_ready;
    assign drn      = full && out_ready[hold_ch];

`ifdef DEMUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0] rr_ptr;
    logic             rr_sel;

    assign rr_sel = (demux_mode_e'(mode) == MODE_RR);

    demux_rr_pointer #(
        .N(N_OUT)
    ) u_rr_pointer (
        .clk  (clk),
        .reset(reset),
        .adv  (acc && rr_sel),
        .ptr  (rr_ptr)
    );

    assign dest = rr_sel ? rr_ptr : select_lines;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign dest        = select_lines;
`endif

    // Only reachable when N_OUT is not a power of two.
    assign bad  = (32'(dest) >= 32'(N_OUT));
    assign load = acc && !bad;

    always_comb begin
        nxt_state = state;
        nxt_data  = hold_data;
        nxt_ch    = hold_ch;
        unique case (state)
            ST_EMPTY: begin
                if (load) begin
                    nxt_state = ST_FULL;
                    nxt_data  = in_data;
                    nxt_ch    = dest;
                end
            end
            ST_FULL: begin
                if (load) begin
                    nxt_data = in_data;
                    nxt_ch   = dest;
                end else if (drn) begin
                    nxt_state = ST_EMPTY;
                end
            end
            default: nxt_state = ST_EMPTY;
        endcase
    end

    // Lanes other than the held channel are forced to zero.
    always_comb begin
        nxt_valid = '0;
        nxt_lanes = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (nxt_state == ST_FULL && nxt_ch == SEL_W'(k)) begin
                nxt_valid[k]                   = 1'b1;
                nxt_lanes[k*DATA_W +: DATA_W]  = nxt_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            hold_data   <= '0;
            hold_ch     <= '0;
            out_valid   <= '0;
            out_data    <= '0;
            cur_channel <= '0;
            sel_err     <= 1'b0;
        end else begin
            state       <= nxt_state;
            hold_data   <= nxt_data;
            hold_ch     <= nxt_ch;
            out_valid   <= nxt_valid;
            out_data    <= nxt_lanes;
            cur_channel <= (nxt_state == ST_FULL) ? nxt_ch : '0;
            sel_err     <= acc && bad;
        end
    end

endmodule

// File: doc/demultiplexer_1_to_n_stream.md
# demultiplexer_1_to_n_stream

Parametrised, registered 1-to-N stream demultiplexer; the clocked successor of the 1-to-4 behavioural demultiplexer. Routes each accepted input word to one of `N_OUT` output channels using valid/ready handshakes and a single output register stage. The destination comes from `select_lines` or, optionally, from an internal round-robin pointer. Unselected channels are driven to defined zeros, never `x`.

## Interface
- `DATA_W`, default 8: data word width in bits.
- `N_OUT`, default 4: number of output channels, 2..16, need not be a power of two.
- `SEL_W`, derived localparam `$clog2(N_OUT)`: select width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  DATA_W  input word.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept `in_data` this cycle.
- `select_lines`  in  SEL_W  destination channel; sampled only on an accepted transfer.
- `mode`  in  1  0 = select mode, 1 = round-robin mode. Ignored unless the round-robin macro is defined.
- `out_data`  out  N_OUT*DATA_W  lane k = bits [k*DATA_W +: DATA_W].
- `out_valid`  out  N_OUT  one-hot or zero.
- `out_ready`  in  N_OUT  per-channel consumer ready.
- `cur_channel`  out  SEL_W  channel held in the output register. Reads 0 when empty.
- `sel_err`  out  1  one-cycle pulse: an accepted word had `select_lines >= N_OUT`.

## Operation
- Internal state is a single holding register: `full`, `hold_data`, `hold_ch`.
- States:
  - EMPTY (`full=0`).
  - FULL (`full=1`).
- Accept condition: `acc = in_valid && in_ready`.
- `in_ready = !reset && (!full || out_ready[hold_ch])`. This is pass-through: a drain and a new accept may occur in the same cycle.
- Drain condition: `drn = full && out_ready[hold_ch]`.
- Transitions:
  - EMPTY –acc→ FULL.
  - FULL –drn && !acc→ EMPTY.
  - FULL –drn && acc→ FULL, register reloaded.
  - Otherwise hold.
- Destination:
  - Select mode: `select_lines`.
  - Round-robin mode: `rr_ptr`.
- Out-of-range select (`select_lines >= N_OUT`, non-power-of-two `N_OUT` only):
  - Word is accepted and discarded.
  - State is unchanged, except that a FULL→EMPTY drain in that cycle still occurs.
  - `sel_err` pulses the next cycle.
- Outputs:
  - `out_valid[k] = full && hold_ch == k`.
  - Lane `hold_ch` carries `hold_data`; all other lanes are 0. All lanes are 0 when EMPTY.
- Holding register is stable while FULL and not drained, so the data is AXI-stream-like stable under backpressure.
- `rr_ptr`:
  - Advances by 1 on each accepted round-robin word.
  - Wraps from `N_OUT-1` to 0.
  - Not touched in select mode; not reset by mode changes.
- A `mode` change takes effect on the next accept. A word already held keeps its channel.

## Timing
- Reset values (the cycle after `reset` is sampled high):
  - `full=0`, `out_valid=0`, `out_data=0`, `cur_channel=0`, `sel_err=0`, `rr_ptr=0`.
  - `in_ready=0` while `reset` is high.
- Reset mid-transfer discards the held word with no output.
- Latency: a word accepted at edge n is valid on its channel after edge n; 1 cycle.
- Throughput: 1 word/cycle while the target channel is ready.
- Registered outputs: `out_data`, `out_valid`, `cur_channel`, `sel_err`.
- Combinational paths:
  - `in_ready` from `out_ready` and `reset` (single mux path).
  - No path from `in_valid` to `in_ready`.

## Configuration
- Macro `DEMUX_ROUND_ROBIN_EN`.
- Defined:
  - `rr_ptr` and round-robin mode are compiled in.
  - `mode=1` selects the pointer.
- Undefined:
  - No pointer logic.
  - `mode` is ignored; the block always behaves as select mode.

## Structure
- Shared package `demux_pkg`:
  - `demux_mode_e` (`MODE_SELECT=0`, `MODE_RR=1`).
  - `demux_state_e` (`ST_EMPTY`, `ST_FULL`).
- Sub-module `demux_rr_pointer`:
  - Parameter `N`.
  - Ports `clk`, `reset`, `adv`, `ptr`.
  - Modulo-N wrap counter.
  - Instantiated only under `DEMUX_ROUND_ROBIN_EN`.

## Test plan
- Reset: hold `reset` 2 cycles with `in_valid=1` → `in_ready=0`, all `out_valid=0`, `out_data=0`. The first cycle after reset has `in_ready=1`.
- Select sweep, `N_OUT=4`, all ready, data 8'hA5 with select 0,1,2,3 on consecutive cycles:
  - `out_valid` = 0001, 0010, 0100, 1000, each one cycle later.
  - Lane k = A5, other lanes 0.
- Backpressure: word 8'h3C to channel 2 with `out_ready[2]=0` for 3 cycles:
  - `out_valid[2]` and data stay stable.
  - `in_ready=0` during the stall.
  - Raising `out_ready[2]` with a new word pending gives drain and accept in the same cycle.
- Round robin (macro defined, `mode=1`), 6 words 1..6 with `select_lines` held at 0:
  - Channels 0,1,2,3,0,1 in that order.
  - Switching to `mode=0` mid-stream takes effect on the next accept.
- Out-of-range, `N_OUT=5`, `select_lines=6`:
  - Word accepted with no `out_valid`.
  - `sel_err` is a 1-cycle pulse.
  - A following valid word to channel 4 is delivered.
- Reset while FULL holding 8'hFF on channel 1 → `out_valid=0` the next cycle; the word is never delivered.
